// File: rtl/grid_map_renderer.sv
// Tile-map video painter: internal timing generator, GRID_W x GRID_H cells from a sync-read map RAM, runtime palette.
// Define GRID_MAP_LINE_EN to draw 1-pixel cell borders in the inverse of palette entry 0.
module grid_map_renderer #(
    parameter int H_TOTAL   = 1056,
    parameter int H_SYNC    = 128,
    parameter int H_BPORCH  = 88,
    parameter int H_RES     = 800,
    parameter int V_TOTAL   = 628,
    parameter int V_SYNC    = 4,
    parameter int V_BPORCH  = 23,
    parameter int V_RES     = 600,
    parameter int GRID_W    = 16,
    parameter int GRID_H    = 16,
    parameter int CELL_PX   = 30,
    parameter int X0        = 160,
    parameter int Y0        = 60,
    parameter int CELL_BITS = 2,
    parameter int ADDR_W    = 8
) (
    input  logic                          I_pxl_clk,
    input  logic                          I_rst,
    input  logic                          I_en,
    input  logic [CELL_BITS-1:0]          I_map_data,
    input  logic [24*(2**CELL_BITS)-1:0]  I_palette,
    input  logic [23:0]                   I_bg_color,
    output logic [ADDR_W-1:0]             O_map_addr,
    output logic                          O_busy,
    output logic                          O_frame_done,
    output logic                          O_de,
    output logic                          O_hs,
    output logic                          O_vs,
    output logic [23:0]                   O_color
);
    // state | meaning
    // IDLE  | counters parked at 0, video outputs quiet, waiting for I_en
    // RUN   | counters free-running; frame boundary decides RUN or IDLE

    localparam int HW     = $clog2(H_TOTAL);
    localparam int VW     = $clog2(V_TOTAL);
    localparam int SW     = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
    localparam int H_ACT0 = H_SYNC + H_BPORCH;
    localparam int V_ACT0 = V_SYNC + V_BPORCH;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic [SW-1:0]     sub_x, sub_y;
    logic [ADDR_W-1:0] col, row_base;
    int                px, py;
    logic              run, h_wrap, v_last, hs0, vs0, de0, grid0;
    logic [1:0]        de_p, hs_p, vs_p, grid_p;
`ifdef GRID_MAP_LINE_EN
    logic [1:0]        edge_p;
`endif

    always_comb begin
        run    = (state == RUN);
        px     = int'(h_cnt) - H_ACT0;
        py     = int'(v_cnt) - V_ACT0;
        h_wrap = (int'(h_cnt) == H_TOTAL - 1);
        v_last = (int'(v_cnt) == V_TOTAL - 1);
        hs0    = run && (int'(h_cnt) < H_SYNC);
        vs0    = run && (int'(v_cnt) < V_SYNC);
        de0    = run && (px >= 0) && (px < H_RES) && (py >= 0) && (py < V_RES);
        grid0  = de0 && (px >= X0) && (px < X0 + GRID_W*CELL_PX)
                     && (py >= Y0) && (py < Y0 + GRID_H*CELL_PX);
    end

    always_ff @(posedge I_pxl_clk or posedge I_rst) begin
        if (I_rst) begin
            state        <= IDLE;
            h_cnt        <= '0;
            v_cnt        <= '0;
            O_busy       <= 1'b0;
            O_frame_done <= 1'b0;
        end else begin
            O_frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    h_cnt <= '0;
                    v_cnt <= '0;
                    if (I_en) begin
                        state  <= RUN;
                        O_busy <= 1'b1;
                    end
                end
                RUN: begin
                    if (h_wrap) begin
                        h_cnt <= '0;
                        if (v_last) begin
                            v_cnt        <= '0;
                            O_frame_done <= 1'b1;
                            if (!I_en) begin
                                state  <= IDLE;
                                O_busy <= 1'b0;
                            end
                        end else begin
                            v_cnt <= v_cnt + 1'b1;
                        end
                    end else begin
                        h_cnt <= h_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Cell position tracked incrementally; re-anchored one pixel/line before the grid edge.
    always_ff @(posedge I_pxl_clk or posedge I_rst) begin
        if (I_rst) begin
            sub_x    <= '0;
            col      <= '0;
            sub_y    <= '0;
            row_base <= '0;
        end else if (run) begin
            if (px == X0 - 1) begin
                sub_x <= '0;
                col   <= '0;
            end else if (int'(sub_x) == CELL_PX - 1) begin
                sub_x <= '0;
                col   <= col + 1'b1;
            end else begin
                sub_x <= sub_x + 1'b1;
            end
            if (h_wrap) begin
                if (int'(v_cnt) == V_ACT0 + Y0 - 1) begin
                    sub_y    <= '0;
                    row_base <= '0;
                end else if (int'(sub_y) == CELL_PX - 1) begin
                    sub_y    <= '0;
                    row_base <= row_base + ADDR_W'(GRID_W);
                end else begin
                    sub_y <= sub_y + 1'b1;
                end
            end
        end
    end

    // Stage 1 issues the address, the RAM register is stage 2, stage 3 picks the colour.
    always_ff @(posedge I_pxl_clk or posedge I_rst) begin
        if (I_rst) begin
            de_p       <= '0;
            hs_p       <= '0;
            vs_p       <= '0;
            grid_p     <= '0;
`ifdef GRID_MAP_LINE_EN
            edge_p     <= '0;
`endif
            O_map_addr <= '0;
            O_de       <= 1'b0;
            O_hs       <= 1'b0;
            O_vs       <= 1'b0;
            O_color    <= '0;
        end else begin
            de_p   <= {de_p[0], de0};
            hs_p   <= {hs_p[0], hs0};
            vs_p   <= {vs_p[0], vs0};
            grid_p <= {grid_p[0], grid0};
`ifdef GRID_MAP_LINE_EN
            edge_p <= {edge_p[0], (sub_x == '0) || (sub_y == '0)};
`endif
            if (grid0)
                O_map_addr <= row_base + col;
            O_de <= de_p[1];
            O_hs <= hs_p[1];
            O_vs <= vs_p[1];
            if (!de_p[1])
                O_color <= '0;
            else if (!grid_p[1])
                O_color <= I_bg_color;
`ifdef GRID_MAP_LINE_EN
            else if (edge_p[1])
                O_color <= ~I_palette[23:0];
`endif
            else
                O_color <= I_palette[int'(I_map_data)*24 +: 24];
        end
    end
endmodule

// File: tb/tb_grid_map_renderer.sv
// Directed bench for grid_map_renderer on a scaled-down raster (64x40 total, 44x30 active, 8x8 grid of 4-px cells).
`timescale 1ns/1ps
module tb_grid_map_renderer;
    localparam int HT = 64, HS = 8, HBP = 6, HR = 44;
    localparam int VT = 40, VS = 2, VBP = 3, VR = 30;
    localparam int GW = 8, GH = 8, CP = 4, X0 = 6, Y0 = 2, CB = 2, AW = 6;
    localparam int FRAME = HT * VT;
    localparam logic [23:0] P0 = 24'h0000FF, P1 = 24'h00FF00, P2 = 24'hFF0000, P3 = 24'h808080;
    localparam logic [23:0] BG = 24'h123456;
`ifdef GRID_MAP_LINE_EN
    localparam bit LINES = 1'b1;
`else
    localparam bit LINES = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, en;
    logic [CB-1:0] map_data;
    logic [95:0]   palette;
    logic [23:0]   bg;
    logic [AW-1:0] map_addr;
    logic          busy, done, de, hs, vs;
    logic [23:0]   color;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int t0;

    grid_map_renderer #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BPORCH(HBP), .H_RES(HR),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BPORCH(VBP), .V_RES(VR),
        .GRID_W(GW), .GRID_H(GH), .CELL_PX(CP), .X0(X0), .Y0(Y0),
        .CELL_BITS(CB), .ADDR_W(AW)
    ) dut (
        .I_pxl_clk(clk), .I_rst(rst), .I_en(en), .I_map_data(map_data),
        .I_palette(palette), .I_bg_color(bg), .O_map_addr(map_addr),
        .O_busy(busy), .O_frame_done(done), .O_de(de), .O_hs(hs), .O_vs(vs),
        .O_color(color)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) map_data <= map_addr[1:0];

    function automatic logic [23:0] exp_col(input int code, input bit border);
        if (code == 5) return 24'h0;
        if (code == 4) return BG;
        if (LINES && border) return ~P0;
        case (code)
            0: return P0;
            1: return P1;
            2: return P2;
            default: return P3;
        endcase
    endfunction

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic start_run();
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t0 = cyc;
    endtask

    task automatic measure_frame(input int base,
                                 output int hs_n, output int vs_n, output int de_n,
                                 output int hs_r, output int vs_r, output int de_r,
                                 output int hs_f1, output int vs_f1, output int de_r1,
                                 output int done_n, output int done_rel, output int max_a);
        logic phs, pvs, pde;
        hs_n = 0; vs_n = 0; de_n = 0; hs_r = 0; vs_r = 0; de_r = 0;
        hs_f1 = -1; vs_f1 = -1; de_r1 = -1; done_n = 0; done_rel = -1; max_a = 0;
        wait_cyc(base + 2);
        phs = hs; pvs = vs; pde = de;
        for (int c = base + 3; c < base + 3 + FRAME; c++) begin
            wait_cyc(c);
            if (hs) hs_n++;
            if (vs) vs_n++;
            if (de) de_n++;
            if (hs && !phs) hs_r++;
            if (vs && !pvs) vs_r++;
            if (de && !pde) begin
                de_r++;
                if (de_r1 < 0) de_r1 = c - base;
            end
            if (!hs && phs && hs_f1 < 0) hs_f1 = c - base;
            if (!vs && pvs && vs_f1 < 0) vs_f1 = c - base;
            if (done) begin
                done_n++;
                done_rel = c - base;
            end
            if (int'(map_addr) > max_a) max_a = int'(map_addr);
            phs = hs; pvs = vs; pde = de;
        end
    endtask

    task automatic test_reset();
        int bad_cycles = 0;
        rst = 1'b1;
        en  = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, done, de, hs, vs, color, map_addr} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got %h want 0", {busy, done, de, hs, vs, color, map_addr});
        end
        rst = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if ({busy, done, de, hs, vs, color, map_addr} !== '0) bad_cycles++;
        end
        n_cmp++;
        if (bad_cycles !== 0) begin
            n_bad++;
            $display("FAIL idle_quiet nonzero cycles got %0d want 0", bad_cycles);
        end
    endtask

    task automatic test_pixels();
        int th [9] = '{20, 24, 21, 25, 29, 33, 20, 25, 49};
        int tv [9] = '{ 7,  7,  8,  8,  8,  8, 11, 12, 34};
        int tc [9] = '{ 0,  1,  0,  1,  2,  3,  0,  1,  3};
        bit tb [9] = '{ 1,  1,  0,  0,  0,  0,  1,  0,  0};
        int ta [9] = '{ 0, -1, -1, -1, -1, -1, -1,  9, -1};
        logic [23:0] exp;
        start_run();
        for (int i = 0; i < 9; i++) begin
            wait_cyc(t0 + tv[i]*HT + th[i] + 3);
            exp = exp_col(tc[i], tb[i]);
            n_cmp++;
            if (color !== exp) begin
                n_bad++;
                $display("FAIL grid_color h=%0d v=%0d got %h want %h", th[i], tv[i], color, exp);
            end
            n_cmp++;
            if (de !== 1'b1) begin
                n_bad++;
                $display("FAIL grid_de h=%0d v=%0d got %b want 1", th[i], tv[i], de);
            end
            if (ta[i] >= 0) begin
                n_cmp++;
                if (map_addr !== AW'(ta[i])) begin
                    n_bad++;
                    $display("FAIL grid_addr h=%0d v=%0d got %0d want %0d", th[i], tv[i], map_addr, ta[i]);
                end
            end
        end
    endtask

    task automatic test_timing();
        int hs_n, vs_n, de_n, hs_r, vs_r, de_r, hs_f1, vs_f1, de_r1, done_n, done_rel, max_a;
        measure_frame(t0 + FRAME, hs_n, vs_n, de_n, hs_r, vs_r, de_r, hs_f1, vs_f1, de_r1,
                      done_n, done_rel, max_a);
        n_cmp++; if (hs_n !== 320)  begin n_bad++; $display("FAIL timing_hs_cycles got %0d want 320", hs_n); end
        n_cmp++; if (vs_n !== 128)  begin n_bad++; $display("FAIL timing_vs_cycles got %0d want 128", vs_n); end
        n_cmp++; if (de_n !== 1320) begin n_bad++; $display("FAIL timing_de_cycles got %0d want 1320", de_n); end
        n_cmp++; if (hs_r !== 40)   begin n_bad++; $display("FAIL timing_lines got %0d want 40", hs_r); end
        n_cmp++; if (vs_r !== 1)    begin n_bad++; $display("FAIL timing_vs_rises got %0d want 1", vs_r); end
        n_cmp++; if (de_r !== 30)   begin n_bad++; $display("FAIL timing_de_lines got %0d want 30", de_r); end
        n_cmp++; if (hs_f1 !== 11)  begin n_bad++; $display("FAIL timing_hs_fall got %0d want 11", hs_f1); end
        n_cmp++; if (vs_f1 !== 131) begin n_bad++; $display("FAIL timing_vs_fall got %0d want 131", vs_f1); end
        n_cmp++; if (de_r1 !== 337) begin n_bad++; $display("FAIL timing_de_rise got %0d want 337", de_r1); end
        n_cmp++; if (done_n !== 1)  begin n_bad++; $display("FAIL timing_done_count got %0d want 1", done_n); end
        n_cmp++; if (done_rel !== FRAME) begin n_bad++; $display("FAIL timing_done_pos got %0d want %0d", done_rel, FRAME); end
        n_cmp++; if (max_a !== 55)  begin n_bad++; $display("FAIL timing_max_addr got %0d want 55", max_a); end
    endtask

    task automatic test_boundaries();
        int th [8] = '{14, 24, 19, 52, 57,  2, 25, 24};
        int tv [8] = '{ 5,  5,  7,  7,  7, 10, 34, 35};
        int tc [8] = '{ 4,  4,  4,  4,  4,  5,  1,  5};
        bit td [8] = '{ 1,  1,  1,  1,  1,  0,  1,  0};
        int ta [8] = '{-1, -1, -1, -1,  7, -1, -1, -1};
        int base = t0 + 2*FRAME;
        logic [23:0] exp;
        for (int i = 0; i < 8; i++) begin
            wait_cyc(base + tv[i]*HT + th[i] + 3);
            exp = exp_col(tc[i], 1'b0);
            n_cmp++;
            if (color !== exp) begin
                n_bad++;
                $display("FAIL edge_color h=%0d v=%0d got %h want %h", th[i], tv[i], color, exp);
            end
            n_cmp++;
            if (de !== td[i]) begin
                n_bad++;
                $display("FAIL edge_de h=%0d v=%0d got %b want %b", th[i], tv[i], de, td[i]);
            end
            if (ta[i] >= 0) begin
                n_cmp++;
                if (map_addr !== AW'(ta[i])) begin
                    n_bad++;
                    $display("FAIL edge_addr_hold h=%0d v=%0d got %0d want %0d", th[i], tv[i], map_addr, ta[i]);
                end
            end
        end
    endtask

    task automatic test_en_drop();
        int base = t0 + 3*FRAME;
        int pulses = 0;
        int idle_bad = 0;
        wait_cyc(base + 20*HT);
        en = 1'b0;
        for (int c = base + 20*HT + 1; c <= base + FRAME + 300; c++) begin
            wait_cyc(c);
            if (done) pulses++;
            if (c == base + 30*HT + 25 + 3) begin
                n_cmp++;
                if (color !== P1 || de !== 1'b1) begin
                    n_bad++;
                    $display("FAIL drop_no_truncate got de=%b color=%h want de=1 color=%h", de, color, P1);
                end
            end
            if (c == base + FRAME - 1) begin
                n_cmp++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    n_bad++;
                    $display("FAIL drop_last_cycle got busy=%b done=%b want busy=1 done=0", busy, done);
                end
            end
            if (c == base + FRAME) begin
                n_cmp++;
                if (busy !== 1'b0 || done !== 1'b1) begin
                    n_bad++;
                    $display("FAIL drop_frame_end got busy=%b done=%b want busy=0 done=1", busy, done);
                end
            end
            if (c > base + FRAME + 3 && (busy || de || hs || vs || color !== 24'h0)) idle_bad++;
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++;
            $display("FAIL drop_done_pulses got %0d want 1", pulses);
        end
        n_cmp++;
        if (idle_bad !== 0) begin
            n_bad++;
            $display("FAIL drop_idle_quiet got %0d want 0", idle_bad);
        end
        start_run();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_busy got %b want 1", busy);
        end
        wait_cyc(t0 + 2);
        n_cmp++;
        if (hs !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_hs_early got %b want 0", hs);
        end
        wait_cyc(t0 + 3);
        n_cmp++;
        if (hs !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_hs_start got %b want 1", hs);
        end
        wait_cyc(t0 + 8*HT + 21 + 3);
        n_cmp++;
        if (color !== P0 || de !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_pixel got de=%b color=%h want de=1 color=%h", de, color, P0);
        end
    endtask

    task automatic test_reset_midframe();
        int hs_n, vs_n, de_n, hs_r, vs_r, de_r, hs_f1, vs_f1, de_r1, done_n, done_rel, max_a;
        wait_cyc(t0 + 13*HT + 30);
        n_cmp++;
        if (de !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_pre got de=%b busy=%b want 1 1", de, busy);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, de, hs, vs, color, map_addr} !== '0) begin
            n_bad++;
            $display("FAIL rst_async got %h want 0", {busy, done, de, hs, vs, color, map_addr});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        t0 = cyc;
        measure_frame(t0, hs_n, vs_n, de_n, hs_r, vs_r, de_r, hs_f1, vs_f1, de_r1,
                      done_n, done_rel, max_a);
        n_cmp++; if (hs_n !== 320)  begin n_bad++; $display("FAIL rst_hs_cycles got %0d want 320", hs_n); end
        n_cmp++; if (vs_n !== 128)  begin n_bad++; $display("FAIL rst_vs_cycles got %0d want 128", vs_n); end
        n_cmp++; if (de_n !== 1320) begin n_bad++; $display("FAIL rst_de_cycles got %0d want 1320", de_n); end
        n_cmp++; if (hs_r !== 40)   begin n_bad++; $display("FAIL rst_lines got %0d want 40", hs_r); end
        n_cmp++; if (vs_r !== 1)    begin n_bad++; $display("FAIL rst_vs_rises got %0d want 1", vs_r); end
        n_cmp++; if (de_r !== 30)   begin n_bad++; $display("FAIL rst_de_lines got %0d want 30", de_r); end
        n_cmp++; if (hs_f1 !== 11)  begin n_bad++; $display("FAIL rst_hs_fall got %0d want 11", hs_f1); end
        n_cmp++; if (vs_f1 !== 131) begin n_bad++; $display("FAIL rst_vs_fall got %0d want 131", vs_f1); end
        n_cmp++; if (de_r1 !== 337) begin n_bad++; $display("FAIL rst_de_rise got %0d want 337", de_r1); end
        n_cmp++; if (done_n !== 1)  begin n_bad++; $display("FAIL rst_done_count got %0d want 1", done_n); end
        n_cmp++; if (done_rel !== FRAME) begin n_bad++; $display("FAIL rst_done_pos got %0d want %0d", done_rel, FRAME); end
        n_cmp++; if (max_a !== 55)  begin n_bad++; $display("FAIL rst_max_addr got %0d want 55", max_a); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        palette = {P3, P2, P1, P0};
        bg      = BG;
        test_reset();
        test_pixels();
        test_timing();
        test_boundaries();
        test_en_drop();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/grid_map_renderer.md
Name: grid_map_renderer

Overview:
Parametrised successor of the 16x16 snake-map HDMI painter. It generates video timing internally and renders a GRID_W x GRID_H tile grid of CELL_PX-square cells at a programmable origin. Cell contents come from a synchronous-read map RAM port, CELL_BITS wide per cell, instead of flattened row inputs. Each cell value indexes a runtime palette. The block sits between the game-state RAM and the TMDS encoder.

Parameters:
H_TOTAL, 1056, horizontal total clocks per line
H_SYNC, 128, hsync width
H_BPORCH, 88, horizontal back porch
H_RES, 800, active pixels per line
V_TOTAL, 628, lines per frame
V_SYNC, 4, vsync width in lines
V_BPORCH, 23, vertical back porch
V_RES, 600, active lines
GRID_W, 16, cells per grid row
GRID_H, 16, cells per grid column
CELL_PX, 30, cell edge in pixels
X0, 160, grid left edge, active-pixel coordinate
Y0, 60, grid top edge, active-line coordinate
CELL_BITS, 2, bits per map cell
ADDR_W, 8, map address width; must satisfy 2^ADDR_W >= GRID_W*GRID_H

Ports:
I_pxl_clk  in  1  pixel clock
I_rst  in  1  asynchronous active-high reset
I_en  in  1  level enable
I_map_data  in  CELL_BITS  map RAM read data; valid 1 cycle after O_map_addr
I_palette  in  24*2^CELL_BITS  colour for cell value k at bits [24k+23:24k], {B,G,R}
I_bg_color  in  24  colour outside the grid, {B,G,R}
O_map_addr  out  ADDR_W  map RAM read address = row*GRID_W + col
O_busy  out  1  a frame is in progress
O_frame_done  out  1  one-cycle pulse at the end of each rendered frame
O_de  out  1  data enable
O_hs  out  1  hsync, active high
O_vs  out  1  vsync, active high
O_color  out  24  pixel colour {B,G,R}

Behaviour:
- Reset: all outputs 0; counters 0; FSM in IDLE. Reset asserted mid-frame aborts the frame immediately.
- FSM states:
  - IDLE: waits for I_en=1. On I_en=1, next state is RUN with h_cnt=v_cnt=0 and O_busy=1.
  - RUN: counters free-run.
    - h_cnt counts 0..H_TOTAL-1 and wraps.
    - v_cnt increments on each h wrap and wraps at V_TOTAL-1.
    - At the end of the last line (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1): O_frame_done pulses for 1 cycle. If I_en=1, RUN continues seamlessly; otherwise go to IDLE with O_busy=0.
    - I_en dropping mid-frame does not truncate the frame.
- Raw timing, stage 0:
  - hs=(h_cnt<H_SYNC); vs=(v_cnt<V_SYNC).
  - de when h_cnt is in [H_SYNC+H_BPORCH, H_SYNC+H_BPORCH+H_RES) and v_cnt is in [V_SYNC+V_BPORCH, V_SYNC+V_BPORCH+V_RES).
  - px, py = active coordinates (counter minus sync+porch).
- Cell tracking, stage 0. Incremental only; no dividers or multipliers.
  - col, sub_x reset at px=X0-1. sub_x wraps at CELL_PX-1 and col then increments.
  - row, sub_y advance once per line at h wrap.
  - row_base accumulates GRID_W per row.
  - in_grid = X0<=px<X0+GRID_W*CELL_PX and Y0<=py<Y0+GRID_H*CELL_PX.
- Pipeline:
  - Stage 1 registers O_map_addr=row_base+col.
  - Stage 2 captures I_map_data.
  - Stage 3 registers O_color = in_grid ? palette[I_map_data] : I_bg_color.
  - O_color is forced to 0 when de=0.
  - O_de, O_hs and O_vs are delayed 3 cycles so they align exactly with O_color.
  - Total latency from counters to outputs is 3 cycles.
- Boundaries:
  - Grid clipped by the active area: cells beyond H_RES/V_RES are not shown and no address beyond GRID_W*GRID_H-1 is issued.
  - O_map_addr holds its last value outside the grid.
  - I_palette and I_bg_color are sampled every pixel; mid-frame changes take effect 3 cycles later.

Optional Feature:
GRID_MAP_LINE_EN:
- Defined: pixels with sub_x==0 or sub_y==0 inside the grid output colour I_palette entry 0 inverted (bitwise NOT), drawing 1-pixel cell borders. Latency and addressing are unchanged.
- Undefined: no borders; the datapath is exactly as above.

Test Plan:
1. Reset held 5 cycles, then released with I_en=0 -> all outputs 0 and O_busy=0 for 2000 cycles.
2. I_en=1, map RAM model returns addr[1:0] -> first grid pixel (px=160, py=60) shows palette[0]. Pixel (190,60) shows palette[1]. Pixel (160,90) shows palette[0], since addr is 16.
3. Count timing over one frame -> 1056 clocks/line, 628 lines. O_hs high for 128 clocks/line, O_vs high for 4 lines, 480000 O_de cycles. O_de edges 3 cycles after the raw-counter edges.
4. Pixel (159,60) and pixel (640,60) -> I_bg_color. O_map_addr never exceeds 255.
5. Drop I_en at v_cnt=300 -> frame completes, one O_frame_done pulse, then O_busy=0. Reassert I_en -> a new frame starts with h_cnt=v_cnt=0.
6. Assert I_rst at v_cnt=200 -> outputs 0 asynchronously. After release with I_en=1, the next frame is timing-identical to test 3.
